line_window_buffer: RTL
=======================

# line_window_buffer

Streaming K×K sliding-window generator for the CNN convolution path. It accepts one pixel per handshake in raster order and stores the previous KERNEL-1 image rows in rotating single-port-read SRAM line buffers. It emits one full KERNEL×KERNEL window for every valid (unpadded) convolution position. It sits between the pixel/feature source and the MAC array, and replaces the fixed 2-line, 3×3 buffering with a depth-, width- and kernel-parametrised block that has backpressure and frame tracking.

## Interface
- DATA_WIDTH, 16, bits per pixel/feature
- IMG_WIDTH, 30, pixels per row (≥ KERNEL)
- IMG_HEIGHT, 30, rows per frame (≥ KERNEL)
- KERNEL, 3, window edge (2..7)
- ADDR_WIDTH, $clog2(IMG_WIDTH), line-buffer address width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  DATA_WIDTH  pixel, raster order
- out_valid  out  1  out_window valid
- out_ready  in  1  consumer accepts window
- out_window  out  KERNEL*KERNEL*DATA_WIDTH  element (i*KERNEL+j) at [(i*KERNEL+j)*DATA_WIDTH +: DATA_WIDTH]; i=row, j=col, 0 = oldest/top-left
- out_row, out_col  out  $clog2(IMG_HEIGHT), ADDR_WIDTH  image coordinates of the window's bottom-right pixel
- frame_done  out  1  high with the last window of a frame

## Operation
- Transfer rules: a pixel is accepted when in_valid && in_ready. A window is consumed when out_valid && out_ready.
- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) advance per accepted pixel. At col wrap, row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and the next frame starts with no gap.
- Line-buffer ring of KERNEL-1 SRAMs, IMG_WIDTH deep. Pointer wr_sel marks the buffer holding the oldest row; it rotates (mod KERNEL-1) at each row wrap and resets to 0 at frame wrap.
- Stage S1 (accept): register the pixel, col and row, and drive rd_addr=col to all buffers.
- Stage S2:
  - Shift each window row left by one.
  - Insert the buffer read data (ordered oldest→newest by wr_sel) plus the S1 pixel into column KERNEL-1.
  - Write the S1 pixel into buffer wr_sel at address col (write happens after that address has been read).
- out_valid is set at S2 when row ≥ KERNEL-1 && col ≥ KERNEL-1; otherwise the shift is internal only. Windows per frame = (IMG_HEIGHT-KERNEL+1)*(IMG_WIDTH-KERNEL+1).
- Rows from the previous frame still sit in the buffers but are never exposed, because the row gate hides them.
- No arithmetic on data; pixels pass through bit-exact.

## Timing
- Latency: pixel accepted in cycle t → its window has out_valid in cycle t+2 (if not stalled).
- Throughput: 1 pixel/cycle when out_ready=1.
- in_ready = rst_n && (!s1_valid || s2_advance), where s2_advance = !out_valid || out_ready. in_ready is combinational from out_ready; there is no combinational path in_valid→out_*.
- Stall: while out_valid && !out_ready, out_window, out_row, out_col and frame_done hold stable. S1 holds, rd_addr holds, and no SRAM write occurs.
- Reset (rst_n=0 on a clock edge), including mid-frame:
  - col, row and wr_sel go to 0; s1_valid=0, out_valid=0, frame_done=0; out_window, out_row and out_col go to 0.
  - in_ready=0 while rst_n=0.
  - SRAM contents are not cleared; the row gate hides them.
- frame_done is asserted with, and only with, the window where out_row=IMG_HEIGHT-1 and out_col=IMG_WIDTH-1.

## Structure
- Shared package cnn_pkg:
  - window_idx function giving i*KERNEL+j.
  - Default DATA_WIDTH, IMG_WIDTH, IMG_HEIGHT and KERNEL constants.
  - A pixel_t typedef parametrised by DATA_WIDTH.
- Sub-module line_buffer_bank:
  - Generate loop of KERNEL-1 instances of the team's sram primitive.
  - Shared rd_addr; one-hot write enable from wr_sel.
  - Outputs read data reordered oldest→newest.
- Top level holds the counters, the S1/S2 pipeline, the KERNEL×KERNEL window registers and the handshake.

## Test plan
Default config for the bench: IMG_WIDTH=5, IMG_HEIGHT=4, KERNEL=3, in_data = raster index 0..19, out_ready=1.
- Fill and first window: stream the default config → the first out_valid comes 2 cycles after pixel 12 is accepted, with window {0,1,2,5,6,7,10,11,12}, out_row=2, out_col=2. There is no out_valid for pixels 0-11 or at col<2.
- Window count and order: stream the full default frame → exactly 6 windows, with bottom-right pixels 12,13,14,17,18,19. frame_done is high only on pixel 19's window.
- Backpressure: hold out_ready=0 for 5 cycles at the first window → window {0,1,2,5,6,7,10,11,12} is stable, in_ready=0 after S1 fills, and no pixel is lost (the subsequent windows match the no-stall run).
- Back-to-back frames: stream two frames with values 0..19 then 100..119 → the first window of frame 2 is {100,101,102,105,106,107,110,111,112}, with no frame-1 data in it.
- Reset mid-frame: assert rst_n=0 for 1 cycle after pixel 8 → all outputs are 0 and in_ready=0 during reset; a fresh stream afterwards reproduces the first scenario exactly.
- Random in_valid/out_ready gaps (50 %) at KERNEL=5, IMG_WIDTH=8, IMG_HEIGHT=6 → 8 windows, each matching the reference model.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : cnn_pkg                                                |
// | Description : Shared constants, pixel type and window indexing for   |
// |               the CNN convolution path.                              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IMG_WIDTH  = 30;
  localparam int DEF_IMG_HEIGHT = 30;
  localparam int DEF_KERNEL     = 3;

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  // Flat position of window element (row i, col j) in a kernel x kernel window.
  function automatic int window_idx(input int i, input int j, input int kernel);
    return i * kernel + j;
  endfunction

  // Width of a selector over n_bufs buffers; never narrower than one bit.
  function automatic int sel_width(input int n_bufs);
    return (n_bufs > 1) ? $clog2(n_bufs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : line_buffer_bank                                       |
// | Description : Ring of N_BUFS row buffers. All buffers share one read |
// |               address; only buffer 'sel' (oldest row) is written.    |
// |               Read data is rotated so slot 0 is the oldest row.      |
// | Ports       : clk                  clock                             |
// |               rd_en, rd_addr       shared read                       |
// |               wr_en, wr_addr, wr_data  write into buffer 'sel'       |
// |               sel                  index of buffer with oldest row   |
// |               rd_data              N_BUFS words, oldest at slot 0    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module line_buffer_bank
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_IMG_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEF_IMG_WIDTH),
  parameter int N_BUFS     = DEF_KERNEL - 1,
  parameter int SEL_WIDTH  = 1
) (
  input  logic                         clk,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [N_BUFS*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] raw_data [N_BUFS];

  generate
    for (genvar g = 0; g < N_BUFS; g++) begin : g_buf
      sram_1r1w #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_sram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (raw_data[g]),
        .wr_en   (wr_en && (sel == SEL_WIDTH'(g))),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
      );
    end
  endgenerate

  // Slot i comes from buffer (sel + i) mod N_BUFS: sel holds the oldest row
  // and each following buffer in the ring holds the next newer one.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_BUFS; i++) begin
      int                   tmp;
      logic [SEL_WIDTH-1:0] idx;
      tmp = int'(sel) + i;
      if (tmp >= N_BUFS) begin
        tmp = tmp - N_BUFS;
      end
      idx = SEL_WIDTH'(tmp);
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = raw_data[idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_1r1w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sram_1r1w                                              |
// | Description : Simple dual-port SRAM, one synchronous read port and   |
// |               one synchronous write port. Contents are not reset.    |
// | Ports       : clk                       clock                        |
// |               rd_en, rd_addr, rd_data   registered read              |
// |               wr_en, wr_addr, wr_data   write                        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module sram_1r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 30,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    // Read data holds while rd_en is low, so a stalled reader keeps its word.
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : line_window_buffer                                     |
// | Description : Streaming KERNEL x KERNEL sliding-window generator.    |
// |               Raster pixels in, one window per valid convolution     |
// |               position out, with backpressure and frame tracking.    |
// | Ports       : clk, rst_n           clock, sync active-low reset      |
// |               in_valid/in_ready/in_data     pixel input handshake    |
// |               out_valid/out_ready/out_window window output handshake |
// |               out_row, out_col     bottom-right pixel coordinates    |
// |               frame_done           high with last window of a frame  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module line_window_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int KERNEL     = DEF_KERNEL,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  out_window,
  output logic [$clog2(IMG_HEIGHT)-1:0]        out_row,
  output logic [ADDR_WIDTH-1:0]                out_col,
  output logic                                 frame_done
);

  localparam int C_ROW_W = $clog2(IMG_HEIGHT);
  localparam int C_NBUF  = KERNEL - 1;
  localparam int C_SEL_W = sel_width(C_NBUF);
  localparam int C_WIN_W = KERNEL * KERNEL * DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] C_COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [C_ROW_W-1:0]    C_ROW_LAST = C_ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] C_COL_GATE = ADDR_WIDTH'(KERNEL - 1);
  localparam logic [C_ROW_W-1:0]    C_ROW_GATE = C_ROW_W'(KERNEL - 1);
  localparam logic [C_SEL_W-1:0]    C_SEL_LAST = C_SEL_W'(C_NBUF - 1);

  // Input-side position counters and ring pointer.
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [C_ROW_W-1:0]    row_q, row_d;
  logic [C_SEL_W-1:0]    sel_q, sel_d;

  // Stage S1.
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_pix_q,   s1_pix_d;
  logic [ADDR_WIDTH-1:0] s1_col_q,   s1_col_d;
  logic [C_ROW_W-1:0]    s1_row_q,   s1_row_d;
  logic [C_SEL_W-1:0]    s1_sel_q,   s1_sel_d;

  // Stage S2 / outputs.
  logic [C_WIN_W-1:0]    win_q,        win_d;
  logic                  out_valid_q,  out_valid_d;
  logic [C_ROW_W-1:0]    out_row_q,    out_row_d;
  logic [ADDR_WIDTH-1:0] out_col_q,    out_col_d;
  logic                  frame_done_q, frame_done_d;

  logic                           s2_advance;
  logic                           s2_fire;
  logic                           accept;
  logic [C_NBUF*DATA_WIDTH-1:0]   lb_rd_data;
  logic [KERNEL*DATA_WIDTH-1:0]   col_in;

  assign s2_advance = !out_valid_q || out_ready;
  assign s2_fire    = s1_valid_q && s2_advance;
  assign in_ready   = rst_n && (!s1_valid_q || s2_advance);
  assign accept     = in_valid && in_ready;

  // Reads are issued at accept with the live column; the matching write of
  // the same address happens one stage later, after the old row was read.
  line_buffer_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_BUFS     (C_NBUF),
    .SEL_WIDTH  (C_SEL_W)
  ) u_bank (
    .clk     (clk),
    .rd_en   (accept),
    .rd_addr (col_q),
    .wr_en   (s2_fire),
    .wr_addr (s1_col_q),
    .wr_data (s1_pix_q),
    .sel     (s1_sel_q),
    .rd_data (lb_rd_data)
  );

  // New rightmost window column: stored rows oldest first, current pixel last.
  assign col_in = {s1_pix_q, lb_rd_data};

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sel_d = sel_q;
    if (accept) begin
      if (col_q == C_COL_LAST) begin
        col_d = '0;
        if (row_q == C_ROW_LAST) begin
          row_d = '0;
          sel_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          sel_d = (sel_q == C_SEL_LAST) ? '0 : sel_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_pix_d   = s1_pix_q;
    s1_col_d   = s1_col_q;
    s1_row_d   = s1_row_q;
    s1_sel_d   = s1_sel_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_pix_d   = in_data;
      s1_col_d   = col_q;
      s1_row_d   = row_q;
      s1_sel_d   = sel_q;
    end else if (s2_fire) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = frame_done_q;
    if (s2_fire) begin
      // The window shifts on every pixel so it is already full when the
      // position becomes a valid convolution site.
      for (int i = 0; i < KERNEL; i++) begin
        for (int j = 0; j < KERNEL - 1; j++) begin
          win_d[window_idx(i, j, KERNEL)*DATA_WIDTH +: DATA_WIDTH] =
            win_q[window_idx(i, j + 1, KERNEL)*DATA_WIDTH +: DATA_WIDTH];
        end
        win_d[window_idx(i, KERNEL - 1, KERNEL)*DATA_WIDTH +: DATA_WIDTH] =
          col_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      out_valid_d  = (s1_row_q >= C_ROW_GATE) && (s1_col_q >= C_COL_GATE);
      frame_done_d = (s1_row_q == C_ROW_LAST) && (s1_col_q == C_COL_LAST);
      out_row_d    = s1_row_q;
      out_col_d    = s1_col_q;
    end else if (s2_advance) begin
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      sel_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_pix_q     <= '0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      s1_sel_q     <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sel_q        <= sel_d;
      s1_valid_q   <= s1_valid_d;
      s1_pix_q     <= s1_pix_d;
      s1_col_q     <= s1_col_d;
      s1_row_q     <= s1_row_d;
      s1_sel_q     <= s1_sel_d;
      win_q        <= win_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = win_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
